// File: rtl/renode_ahb_pkg.sv
// Shared AHB-Lite types and constants for the Renode AHB manager and its helpers.
// ST_DRAIN exists only when RENODE_AHB_MANAGER_TIMEOUT_EN is defined.
package renode_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
`ifdef RENODE_AHB_MANAGER_TIMEOUT_EN
        ST_RESP,
        ST_DRAIN
`else
        ST_RESP
`endif
    } manager_state_e;

    // Number of bytes moved by one transfer of the given hsize.
    function automatic int size_bytes(input logic [2:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/renode_ahb_manager_if.sv
// Command, response and AHB-Lite bus signals of the manager; master = manager side.
interface renode_ahb_manager_if #(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [AddressWidth-1:0] cmd_addr;
    logic                    cmd_write;
    logic [2:0]              cmd_size;
    logic [DataWidth-1:0]    cmd_wdata;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_error;

    logic [AddressWidth-1:0] haddr;
    logic [1:0]              htrans;
    logic                    hwrite;
    logic [2:0]              hsize;
    logic [2:0]              hburst;
    logic [3:0]              hprot;
    logic [DataWidth-1:0]    hwdata;
    logic                    hready;
    logic                    hresp;
    logic [DataWidth-1:0]    hrdata;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, rsp_ready,
               hready, hresp, hrdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, rsp_ready,
               hready, hresp, hrdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );
endinterface

// File: rtl/renode_ahb_lane_mask.sv
// Byte-lane mask and legality check for a single AHB transfer (size + address offset).
module renode_ahb_lane_mask
    import renode_ahb_pkg::*;
#(
    parameter  int DataWidth   = 32,
    localparam int Bytes       = DataWidth / 8,
    localparam int OffsetWidth = (Bytes > 1) ? $clog2(Bytes) : 1
) (
    input  logic [2:0]             size,
    input  logic [OffsetWidth-1:0] offset,
    output logic [DataWidth-1:0]   mask,
    output logic                   illegal
);
    always_comb begin
        int nbytes;
        int first;
        // NOTE: every output gets a default first, so no branch can infer a latch.
        mask    = '0;
        nbytes  = size_bytes(size);
        first   = (Bytes > 1) ? int'(offset) : 0;
        illegal = (8 * nbytes > DataWidth) || ((first % nbytes) != 0);
        for (int b = 0; b < Bytes; b++) begin
            if (b >= first && b < first + nbytes) mask[8*b +: 8] = 8'hFF;
        end
    end
endmodule

// File: rtl/renode_ahb_manager.sv
// AHB-Lite manager: one command in, at most one non-pipelined transfer, one response out.
// Optional data-phase timeout with bus drain: define RENODE_AHB_MANAGER_TIMEOUT_EN.
module renode_ahb_manager
    import renode_ahb_pkg::*;
#(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                 hclk,
    input  logic                 hreset,
    renode_ahb_manager_if.master bus,
    output logic                 busy
);
    localparam int Bytes       = DataWidth / 8;
    localparam int OffsetWidth = (Bytes > 1) ? $clog2(Bytes) : 1;

    if (!(DataWidth inside {8, 16, 32, 64})) begin : g_bad_width
        $error("renode_ahb_manager: DataWidth must be 8, 16, 32 or 64");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("renode_ahb_manager: TimeoutCycles must be at least 1");
    end

    manager_state_e          state_q, state_d;
    logic [AddressWidth-1:0] haddr_q;
    logic                    hwrite_q;
    logic [2:0]              hsize_q;
    logic [DataWidth-1:0]    hwdata_q;
    logic [DataWidth-1:0]    mask_q;
    logic [DataWidth-1:0]    rdata_q;
    logic                    error_q;
    logic [DataWidth-1:0]    lane_mask;
    logic                    illegal;

    renode_ahb_lane_mask #(.DataWidth(DataWidth)) u_lane_mask (
        .size    (bus.cmd_size),
        .offset  (bus.cmd_addr[OffsetWidth-1:0]),
        .mask    (lane_mask),
        .illegal (illegal)
    );

`ifdef RENODE_AHB_MANAGER_TIMEOUT_EN
    localparam int CountWidth = $clog2(TimeoutCycles + 1);
    logic [CountWidth-1:0] wait_cnt_q;
    logic                  timed_out_q;
    logic                  timeout_hit;

    assign timeout_hit = (state_q == ST_DATA) && !bus.hready &&
                         (wait_cnt_q == CountWidth'(TimeoutCycles - 1));

    // Counter is cleared throughout ADDR, so it starts at zero on entry to DATA.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wait_cnt_q  <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (state_q == ST_ADDR)                      wait_cnt_q <= '0;
            else if (state_q == ST_DATA && !bus.hready)  wait_cnt_q <= wait_cnt_q + 1'b1;
            if (state_q == ST_IDLE)                      timed_out_q <= 1'b0;
            else if (timeout_hit)                        timed_out_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (hreset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) state_d = illegal ? ST_RESP : ST_ADDR;
            ST_ADDR: if (bus.hready)    state_d = ST_DATA;
            ST_DATA: begin
                if (bus.hready) state_d = ST_RESP;
`ifdef RENODE_AHB_MANAGER_TIMEOUT_EN
                else if (timeout_hit) state_d = ST_RESP;
`endif
            end
            ST_RESP: begin
`ifdef RENODE_AHB_MANAGER_TIMEOUT_EN
                if (bus.rsp_ready) state_d = timed_out_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.hready) state_d = ST_IDLE;
`else
                if (bus.rsp_ready) state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE) && !hreset;
        bus.rsp_valid = (state_q == ST_RESP);
        bus.htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        busy          = (state_q != ST_IDLE);
    end

    // Write commands get an all-zero mask so the response data reads back as zero.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hwdata_q <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && illegal) begin
                        rdata_q <= '0;
                        error_q <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        haddr_q  <= bus.cmd_addr;
                        hwrite_q <= bus.cmd_write;
                        hsize_q  <= bus.cmd_size;
                        hwdata_q <= bus.cmd_wdata;
                        mask_q   <= bus.cmd_write ? '0 : lane_mask;
                    end
                end
                ST_DATA: begin
                    if (bus.hready) begin
                        error_q <= bus.hresp;
                        rdata_q <= bus.hresp ? '0 : (bus.hrdata & mask_q);
                    end
`ifdef RENODE_AHB_MANAGER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        error_q <= 1'b1;
                        rdata_q <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hsize     = hsize_q;
    assign bus.hwdata    = hwdata_q;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.hprot     = HPROT_DEFAULT;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;
endmodule

// File: tb/tb_renode_ahb_manager.sv
// Randomized bench for renode_ahb_manager against a transaction-level reference model.
// Covers the timeout/drain path when RENODE_AHB_MANAGER_TIMEOUT_EN is defined.
module tb_renode_ahb_manager;
    import renode_ahb_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 4;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    renode_ahb_manager_if #(.AddressWidth(AW), .DataWidth(DW)) bus();

    renode_ahb_manager #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference rules: a transfer is legal if it fits the bus and is naturally aligned.
    function automatic bit is_legal(input logic [AW-1:0] addr, input logic [2:0] size);
        int nbytes;
        nbytes = 1 << size;
        return (8 * nbytes <= DW) && ((int'(addr) % nbytes) == 0);
    endfunction

    // Read data keeps only the bytes [addr mod lanes, +size) of the bus word.
    function automatic logic [DW-1:0] lane_data(input logic [AW-1:0] addr, input logic [2:0] size,
                                                input logic [DW-1:0] word);
        int nbytes;
        int off;
        logic [63:0] keep;
        nbytes = 1 << size;
        off    = int'(addr) % (DW / 8);
        keep   = (nbytes >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                               : (((64'd1 << (8 * nbytes)) - 64'd1) << (8 * off));
        return word & keep[DW-1:0];
    endfunction

    // One complete command: accept, bus phases (if legal), response hold and release.
    // Called and returns at a falling edge with the manager idle.
    task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [2:0] size,
                           input logic [DW-1:0] wdata, input int a_waits, input int d_waits,
                           input logic err, input logic [DW-1:0] word, input int r_delay);
        bit            legal;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        legal     = is_legal(addr, size);
        exp_err   = !legal || err;
        exp_rdata = (exp_err || wr) ? '0 : lane_data(addr, size, word);

        check("idle_cmd_ready", bus.cmd_ready, 1);
        check("idle_busy", busy, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_write = wr;
        bus.cmd_size  = size;
        bus.cmd_wdata = wdata;
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_write = 1'($urandom);
        bus.cmd_size  = 3'($urandom);
        bus.cmd_wdata = DW'($urandom);

        if (legal) begin
            for (int k = 0; k <= a_waits; k++) begin
                check("addr_htrans", bus.htrans, 2);
                check("addr_haddr", bus.haddr, addr);
                check("addr_hwrite", bus.hwrite, wr);
                check("addr_hsize", bus.hsize, size);
                check("addr_rsp_valid", bus.rsp_valid, 0);
                bus.hready = (k == a_waits);
                @(negedge hclk);
            end
            for (int k = 0; k <= d_waits; k++) begin
                check("data_htrans", bus.htrans, 0);
                check("data_busy", busy, 1);
                check("data_rsp_valid", bus.rsp_valid, 0);
                if (wr) check("data_hwdata", bus.hwdata, wdata);
                bus.hready = (k == d_waits);
                bus.hresp  = err && (k >= d_waits - 1);
                bus.hrdata = (k == d_waits) ? word : DW'($urandom);
                @(negedge hclk);
            end
            bus.hready = 1'b1;
            bus.hresp  = 1'b0;
            bus.hrdata = DW'($urandom);
        end

        for (int k = 0; k <= r_delay; k++) begin
            check("resp_valid", bus.rsp_valid, 1);
            check("resp_rdata", bus.rsp_rdata, exp_rdata);
            check("resp_error", bus.rsp_error, exp_err);
            check("resp_htrans", bus.htrans, 0);
            check("resp_cmd_ready", bus.cmd_ready, 0);
            bus.rsp_ready = (k == r_delay);
            @(negedge hclk);
        end
        bus.rsp_ready = 1'b0;
        check("done_rsp_valid", bus.rsp_valid, 0);
        check("done_busy", busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_rsp_error"}, bus.rsp_error, 0);
        check({tag, "_htrans"}, bus.htrans, 0);
        check({tag, "_haddr"}, bus.haddr, 0);
        check({tag, "_hwrite"}, bus.hwrite, 0);
        check({tag, "_hsize"}, bus.hsize, 0);
        check({tag, "_hwdata"}, bus.hwdata, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic          wr;
        logic          err;
        int            a_w;
        int            d_w;

        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.hready    = 1'b1;
        bus.hresp     = 1'b0;
        bus.hrdata    = '0;

        repeat (2) @(negedge hclk);
        check_reset_values("reset");
        hreset = 1'b0;
        @(negedge hclk);
        check("hburst", bus.hburst, 0);
        check("hprot", bus.hprot, 4'b0011);

        // Directed cases from the plan.
        run_txn(20'h00100, 1'b0, 3'd2, '0, 0, 0, 1'b0, 32'hDEADBEEF, 0);
        run_txn(20'h00003, 1'b1, 3'd0, 32'hAB000000, 0, 3, 1'b0, DW'($urandom), 1);
        run_txn(20'h00002, 1'b0, 3'd1, '0, 0, 0, 1'b0, 32'h12345678, 0);
        run_txn(20'h00010, 1'b1, 3'd2, 32'hCAFEF00D, 0, 1, 1'b1, DW'($urandom), 0);
        run_txn(20'h00001, 1'b0, 3'd2, '0, 0, 0, 1'b0, DW'($urandom), 0);
        run_txn(20'h00008, 1'b0, 3'd3, '0, 0, 0, 1'b0, DW'($urandom), 0);
        run_txn(20'h00045, 1'b0, 3'd0, '0, 2, 1, 1'b0, 32'h11223344, 2);

        for (int i = 0; i < 60; i++) begin
            size = 3'($urandom_range(0, 3));
            addr = AW'($urandom);
            if ($urandom_range(0, 3) != 0) addr = addr & ~AW'((1 << size) - 1);
            wr   = 1'($urandom_range(0, 1));
            a_w  = $urandom_range(0, 2);
            d_w  = $urandom_range(0, 3);
            err  = (d_w > 0) && ($urandom_range(0, 4) == 0);
            run_txn(addr, wr, size, DW'($urandom), a_w, d_w, err, DW'($urandom), $urandom_range(0, 2));
        end

`ifdef RENODE_AHB_MANAGER_TIMEOUT_EN
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 20'h00200;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 3'd2;
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        check("to_addr_htrans", bus.htrans, 2);
        bus.hready = 1'b1;
        @(negedge hclk);
        bus.hready = 1'b0;
        for (int k = 0; k < TO; k++) begin
            check("to_data_busy", busy, 1);
            check("to_data_rsp_valid", bus.rsp_valid, 0);
            @(negedge hclk);
        end
        check("to_rsp_valid", bus.rsp_valid, 1);
        check("to_rsp_error", bus.rsp_error, 1);
        check("to_rsp_rdata", bus.rsp_rdata, 0);
        bus.rsp_ready = 1'b1;
        @(negedge hclk);
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("drain_busy", busy, 1);
            check("drain_cmd_ready", bus.cmd_ready, 0);
            check("drain_htrans", bus.htrans, 0);
            check("drain_rsp_valid", bus.rsp_valid, 0);
            @(negedge hclk);
        end
        bus.hready = 1'b1;
        @(negedge hclk);
        check("drain_exit_busy", busy, 0);
        check("drain_exit_cmd_ready", bus.cmd_ready, 1);
`else
        run_txn(20'h00300, 1'b0, 3'd2, '0, 0, 12, 1'b0, 32'h0BADF00D, 0);
`endif

        // Asynchronous reset in the middle of a data phase; no response may follow.
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 20'h00040;
        bus.cmd_write = 1'b1;
        bus.cmd_size  = 3'd2;
        bus.cmd_wdata = 32'h5A5AA5A5;
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        bus.hready    = 1'b1;
        @(negedge hclk);
        check("pre_reset_busy", busy, 1);
        bus.hready = 1'b0;
        #2 hreset = 1'b1;
        #1 check_reset_values("mid_reset");
        @(negedge hclk);
        hreset     = 1'b0;
        bus.hready = 1'b1;
        @(negedge hclk);
        check("post_reset_rsp_valid", bus.rsp_valid, 0);
        check("post_reset_cmd_ready", bus.cmd_ready, 1);
        run_txn(20'h00104, 1'b0, 3'd2, '0, 0, 0, 1'b0, 32'h76543210, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
